// File: rtl/gpmc_regs_pkg.sv
// Shared constants for the GPMC register-bus controller: local register map,
// STATUS bit positions, external-port FSM encoding and the timeout read value.
package gpmc_regs_pkg;

  localparam logic [15:0] REG_ID      = 16'h0000;
  localparam logic [15:0] REG_SCRATCH = 16'h0001;
  localparam logic [15:0] REG_CTRL    = 16'h0002;
  localparam logic [15:0] REG_STATUS  = 16'h0003;
  localparam logic [15:0] REG_TOCOUNT = 16'h0004;

  localparam int STS_TIMEOUT = 0;
  localparam int STS_DROPPED = 1;
  localparam int STS_COLLIDE = 2;
  localparam int STS_WIDTH   = 3;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_EXT_WAIT = 1'b1
  } ext_state_t;

  // Wide enough for any sensible data width; callers truncate.
  localparam logic [63:0] TIMEOUT_RDATA = '1;

endpackage

// File: rtl/gpmc_ext_port.sv
// External slave port: req/ack handshake with a bounded wait, plus the
// address/write-enable/write-data latches presented to the slave.
//
// state       | meaning
// ST_IDLE     | no external access outstanding, accepts i_start
// ST_EXT_WAIT | o_req high, waiting for i_ack or the timeout
module gpmc_ext_port
  import gpmc_regs_pkg::*;
#(
  parameter int EXT_ADDR_WIDTH = 15,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  input  logic                      i_we,
  input  logic [EXT_ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0]     i_wdata,
  input  logic                      i_ack,
  output logic                      o_req,
  output logic                      o_we,
  output logic [EXT_ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0]     o_wdata,
  output logic                      o_busy,
  output logic                      o_rd_done,
  output logic                      o_timeout
);

  ext_state_t                r_state;
  ext_state_t                w_state_nxt;
  logic [7:0]                r_cnt;
  logic                      r_we;
  logic [EXT_ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]     r_wdata;
  logic                      w_tc;

  // Counter is 0 on the first request cycle, so terminal count at T-1 gives
  // exactly TIMEOUT_CYCLES cycles of o_req.
  assign w_tc = (r_cnt == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:     if (i_start) w_state_nxt = ST_EXT_WAIT;
      ST_EXT_WAIT: if (i_ack || w_tc) w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_req     = (r_state == ST_EXT_WAIT);
    o_busy    = (r_state == ST_EXT_WAIT);
    o_rd_done = (r_state == ST_EXT_WAIT) && i_ack && !r_we;
    o_timeout = (r_state == ST_EXT_WAIT) && !i_ack && w_tc;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (r_state == ST_IDLE) begin
      r_cnt <= '0;
      if (i_start) begin
        r_we    <= i_we;
        r_addr  <= i_addr;
        r_wdata <= i_wdata;
      end
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_we    = r_we;
  assign o_addr  = r_addr;
  assign o_wdata = r_wdata;

endmodule

// File: rtl/gpmc_bus_ctrl.sv
// Host register-bus controller: decodes gpmc_sync accesses, serves the local
// register file in one cycle and forwards the upper window to gpmc_ext_port.
module gpmc_bus_ctrl
  import gpmc_regs_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 16,
  parameter int                    DATA_WIDTH     = 16,
  parameter logic [ADDR_WIDTH-1:0] EXT_BASE       = 16'h8000,
  parameter int                    EXT_ADDR_WIDTH = 15,
  parameter int                    TIMEOUT_CYCLES = 64,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE       = 16'hCC01
) (
  input  logic                      clk_100,
  input  logic                      rst,
  input  logic                      rd_en,
  input  logic                      wr_en,
  input  logic [ADDR_WIDTH-1:0]     address,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      rd_valid,
  output logic                      busy,
  output logic [DATA_WIDTH-1:0]     ctrl,
  output logic                      ext_req,
  output logic                      ext_we,
  output logic [EXT_ADDR_WIDTH-1:0] ext_addr,
  output logic [DATA_WIDTH-1:0]     ext_wdata,
  input  logic [DATA_WIDTH-1:0]     ext_rdata,
  input  logic                      ext_ack
);

  logic [DATA_WIDTH-1:0]     r_rd_data;
  logic                      r_rd_valid;
  logic [DATA_WIDTH-1:0]     r_scratch;
  logic [DATA_WIDTH-1:0]     r_ctrl;
  logic [STS_WIDTH-1:0]      r_status;
  logic [7:0]                r_tocount;

  logic                      w_strobe;
  logic                      w_busy;
  logic                      w_is_ext;
  logic                      w_accept;
  logic                      w_start;
  logic                      w_loc_wr;
  logic                      w_loc_rd;
  logic                      w_rd_done;
  logic                      w_timeout;
  logic                      w_ext_we;
  logic [EXT_ADDR_WIDTH-1:0] w_ext_off;
  logic [DATA_WIDTH-1:0]     w_loc_rdata;
  logic [STS_WIDTH-1:0]      w_sts_set;
  logic [STS_WIDTH-1:0]      w_sts_clr;

  assign w_strobe  = rd_en | wr_en;
  assign w_is_ext  = (address >= EXT_BASE);
  assign w_accept  = w_strobe && !w_busy;
  assign w_start   = w_accept && w_is_ext;
  // A simultaneous rd_en/wr_en is serviced as a write.
  assign w_loc_wr  = w_accept && !w_is_ext && wr_en;
  assign w_loc_rd  = w_accept && !w_is_ext && rd_en && !wr_en;
  assign w_ext_off = EXT_ADDR_WIDTH'(address - EXT_BASE);

  gpmc_ext_port #(
    .EXT_ADDR_WIDTH (EXT_ADDR_WIDTH),
    .DATA_WIDTH     (DATA_WIDTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_ext_port (
    .i_clk     (clk_100),
    .i_rst     (rst),
    .i_start   (w_start),
    .i_we      (wr_en),
    .i_addr    (w_ext_off),
    .i_wdata   (wr_data),
    .i_ack     (ext_ack),
    .o_req     (ext_req),
    .o_we      (w_ext_we),
    .o_addr    (ext_addr),
    .o_wdata   (ext_wdata),
    .o_busy    (w_busy),
    .o_rd_done (w_rd_done),
    .o_timeout (w_timeout)
  );

  always_comb begin
    w_loc_rdata = '0;
    case (address)
      ADDR_WIDTH'(REG_ID):      w_loc_rdata = ID_VALUE;
      ADDR_WIDTH'(REG_SCRATCH): w_loc_rdata = r_scratch;
      ADDR_WIDTH'(REG_CTRL):    w_loc_rdata = r_ctrl;
      ADDR_WIDTH'(REG_STATUS):  w_loc_rdata = DATA_WIDTH'(r_status);
      ADDR_WIDTH'(REG_TOCOUNT): w_loc_rdata = DATA_WIDTH'(r_tocount);
      default:                  w_loc_rdata = '0;
    endcase
  end

  always_comb begin
    w_sts_set              = '0;
    w_sts_set[STS_TIMEOUT] = w_timeout;
    w_sts_set[STS_DROPPED] = w_strobe && w_busy;
    w_sts_set[STS_COLLIDE] = w_accept && rd_en && wr_en;
    w_sts_clr              = '0;
    if (w_loc_wr && (address == ADDR_WIDTH'(REG_STATUS))) begin
      w_sts_clr = wr_data[STS_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_100) begin
    if (rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      if (w_rd_done) begin
        r_rd_data  <= ext_rdata;
        r_rd_valid <= 1'b1;
      end else if (w_timeout && !w_ext_we) begin
        r_rd_data  <= DATA_WIDTH'(TIMEOUT_RDATA);
        r_rd_valid <= 1'b1;
      end else if (w_loc_rd) begin
        r_rd_data  <= w_loc_rdata;
        r_rd_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_100) begin
    if (rst) begin
      r_scratch <= '0;
      r_ctrl    <= '0;
      r_status  <= '0;
      r_tocount <= '0;
    end else begin
      // Hardware set wins over a same-cycle write-1-to-clear.
      r_status <= (r_status & ~w_sts_clr) | w_sts_set;
      if (w_loc_wr && (address == ADDR_WIDTH'(REG_SCRATCH))) r_scratch <= wr_data;
      if (w_loc_wr && (address == ADDR_WIDTH'(REG_CTRL)))    r_ctrl    <= wr_data;
      if (w_timeout) begin
        if (r_tocount != 8'hFF) r_tocount <= r_tocount + 8'd1;
      end else if (w_loc_wr && (address == ADDR_WIDTH'(REG_TOCOUNT))) begin
        r_tocount <= '0;
      end
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign busy     = w_busy;
  assign ctrl     = r_ctrl;
  assign ext_we   = w_ext_we;

endmodule

// File: tb/tb_gpmc_bus_ctrl.sv
// Directed self-checking bench for gpmc_bus_ctrl: local map, external
// handshake with ack and timeout, drop/collision status and reset abort.
module tb_gpmc_bus_ctrl;

  logic        clk_100 = 1'b0;
  logic        rst;
  logic        rd_en;
  logic        wr_en;
  logic [15:0] address;
  logic [15:0] wr_data;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        busy;
  logic [15:0] ctrl;
  logic        ext_req;
  logic        ext_we;
  logic [14:0] ext_addr;
  logic [15:0] ext_wdata;
  logic [15:0] ext_rdata;
  logic        ext_ack;

  int n_checks   = 0;
  int n_failures = 0;
  int req_cycles;

  always #5 clk_100 = ~clk_100;

  gpmc_bus_ctrl dut (
    .clk_100   (clk_100),
    .rst       (rst),
    .rd_en     (rd_en),
    .wr_en     (wr_en),
    .address   (address),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .busy      (busy),
    .ctrl      (ctrl),
    .ext_req   (ext_req),
    .ext_we    (ext_we),
    .ext_addr  (ext_addr),
    .ext_wdata (ext_wdata),
    .ext_rdata (ext_rdata),
    .ext_ack   (ext_ack)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_100);
    #1;
  endtask

  task automatic acc(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
    rd_en   = rd;
    wr_en   = wr;
    address = a;
    wr_data = d;
    tick();
    rd_en   = 1'b0;
    wr_en   = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] a, input logic [15:0] exp);
    acc(1'b1, 1'b0, a, 16'h0000);
    chk({tag, "_valid"}, rd_valid, 1);
    chk(tag, rd_data, exp);
  endtask

  // Counts the cycles ext_req stays high after an accepted strobe, bounded.
  task automatic count_req(output int n);
    n = 1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (!ext_req) break;
      n++;
    end
  endtask

  initial begin
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = '0; wr_data = '0;
    ext_rdata = '0; ext_ack = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ext_req", ext_req, 0);
    chk("rst_ctrl", ctrl, 0);
    chk("rst_ext_addr", ext_addr, 0);
    chk("rst_ext_we", ext_we, 0);
    chk("rst_ext_wdata", ext_wdata, 0);

    rd_chk("rd_id", 16'h0000, 16'hCC01);
    tick();
    chk("rd_valid_pulse", rd_valid, 0);
    chk("rd_data_hold", rd_data, 16'hCC01);
    rd_chk("rd_status0", 16'h0003, 16'h0000);

    acc(1'b0, 1'b1, 16'h0002, 16'h00A5);
    chk("ctrl_out", ctrl, 16'h00A5);
    chk("wr_no_valid", rd_valid, 0);
    rd_chk("rd_ctrl", 16'h0002, 16'h00A5);
    rd_chk("rd_unmapped", 16'h0010, 16'h0000);

    // External read acked 3 cycles after ext_req, then a back-to-back local read.
    acc(1'b1, 1'b0, 16'h8004, 16'h0000);
    chk("xr_req", ext_req, 1);
    chk("xr_busy", busy, 1);
    chk("xr_addr", ext_addr, 15'h0004);
    chk("xr_we", ext_we, 0);
    tick();
    tick();
    chk("xr_req_held", ext_req, 1);
    ext_ack = 1'b1; ext_rdata = 16'h1234;
    tick();
    ext_ack = 1'b0; ext_rdata = 16'h0000;
    chk("xr_req_drop", ext_req, 0);
    chk("xr_busy_drop", busy, 0);
    chk("xr_valid", rd_valid, 1);
    chk("xr_data", rd_data, 16'h1234);
    rd_chk("b2b_rd_id", 16'h0000, 16'hCC01);

    // External write with no ack: timeout.
    acc(1'b0, 1'b1, 16'h9000, 16'hBEEF);
    chk("xw_we", ext_we, 1);
    chk("xw_wdata", ext_wdata, 16'hBEEF);
    chk("xw_addr", ext_addr, 15'h1000);
    count_req(req_cycles);
    chk("xw_req_cycles", req_cycles, 64);
    chk("xw_no_valid", rd_valid, 0);
    chk("xw_data_hold", rd_data, 16'hCC01);
    rd_chk("xw_status", 16'h0003, 16'h0001);
    rd_chk("xw_tocount", 16'h0004, 16'h0001);

    // External read timeout returns all-ones.
    acc(1'b1, 1'b0, 16'h8010, 16'h0000);
    count_req(req_cycles);
    chk("xrt_req_cycles", req_cycles, 64);
    chk("xrt_valid", rd_valid, 1);
    chk("xrt_data", rd_data, 16'hFFFF);
    rd_chk("xrt_tocount", 16'h0004, 16'h0002);
    acc(1'b0, 1'b1, 16'h0003, 16'h0001);
    rd_chk("sts_clr0", 16'h0003, 16'h0000);
    acc(1'b0, 1'b1, 16'h0004, 16'h1234);
    rd_chk("tocount_clr", 16'h0004, 16'h0000);

    // Strobe while busy is dropped.
    acc(1'b1, 1'b0, 16'h8000, 16'h0000);
    acc(1'b0, 1'b1, 16'h0001, 16'h5555);
    chk("drop_busy", busy, 1);
    ext_ack = 1'b1; ext_rdata = 16'hA0A0;
    tick();
    ext_ack = 1'b0;
    chk("drop_ext_data", rd_data, 16'hA0A0);
    rd_chk("drop_scratch", 16'h0001, 16'h0000);
    rd_chk("drop_status", 16'h0003, 16'h0002);
    acc(1'b0, 1'b1, 16'h0003, 16'h0002);
    rd_chk("sts_clr1", 16'h0003, 16'h0000);

    // Simultaneous rd_en/wr_en is a write and flags bit2.
    acc(1'b1, 1'b1, 16'h0001, 16'h0F0F);
    chk("both_no_valid", rd_valid, 0);
    rd_chk("both_scratch", 16'h0001, 16'h0F0F);
    rd_chk("both_status", 16'h0003, 16'h0004);

    // ext_ack in IDLE is ignored.
    ext_ack = 1'b1; ext_rdata = 16'h7777;
    tick();
    ext_ack = 1'b0;
    chk("idle_ack_valid", rd_valid, 0);
    chk("idle_ack_busy", busy, 0);

    // Reset during EXT_WAIT; a late ack must not complete anything.
    acc(1'b1, 1'b0, 16'h8002, 16'h0000);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstw_req", ext_req, 0);
    ext_ack = 1'b1; ext_rdata = 16'h5A5A;
    tick();
    ext_ack = 1'b0;
    chk("rstw_late_valid", rd_valid, 0);
    chk("rstw_busy", busy, 0);
    chk("rstw_rd_data", rd_data, 16'h0000);
    rd_chk("rstw_status", 16'h0003, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

endmodule
